// File: rtl/vga_keyboard_sprite_if.sv
// -----------------------------------------------------------------------------
// vga_keyboard_sprite_if
// Bundles the PS/2 byte stream arriving from the keyboard receiver with the
// VGA pin group and square-position status leaving the sprite engine.
//   rx_data / rx_valid     : scan-code byte plus one-clk strobe (receiver side)
//   hSync / vSync          : active-low sync pulses
//   VGA_R / VGA_G / VGA_B  : 4-bit colour channels
//   sq_x / sq_y            : current square top-left corner
//   frame_start            : one-clk pulse at the start of vertical blank
// master = keyboard receiver / display consumer, slave = sprite engine.
// -----------------------------------------------------------------------------
interface vga_keyboard_sprite_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       hSync;
   logic       vSync;
   logic [3:0] VGA_R;
   logic [3:0] VGA_G;
   logic [3:0] VGA_B;
   logic [9:0] sq_x;
   logic [9:0] sq_y;
   logic       frame_start;

   modport master (
      output rx_data, rx_valid,
      input  hSync, vSync, VGA_R, VGA_G, VGA_B, sq_x, sq_y, frame_start
   );

   modport slave (
      input  rx_data, rx_valid,
      output hSync, vSync, VGA_R, VGA_G, VGA_B, sq_x, sq_y, frame_start
   );
endinterface

// File: rtl/vga_keyboard_sprite.sv
// -----------------------------------------------------------------------------
// vga_keyboard_sprite
// Single-clock VGA engine: generates sync timing from a pixel clock-enable and
// draws one solid square over a background. The square is steered by PS/2
// scan codes (WASD and extended arrow keys, make and break tracked) and moves
// once per frame, only during vertical blank.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : vga_keyboard_sprite_if.slave (PS/2 byte in, VGA pins and
//            square position / frame_start out)
// -----------------------------------------------------------------------------
module vga_keyboard_sprite #(
   parameter int          CLK_DIV  = 4,
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter int          SQ_SIZE  = 32,
   parameter int          STEP     = 4,
   parameter logic [11:0] SQ_COLOR = 12'hF00,
   parameter logic [11:0] BG_COLOR = 12'h000
) (
   input logic                 clk,
   input logic                 reset,
   vga_keyboard_sprite_if.slave bus
);

   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] SQ_W     = 11'(SQ_SIZE);
   localparam logic [10:0] STEP_W   = 11'(STEP);
   localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SQ_SIZE);
   localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SQ_SIZE);
   localparam logic [9:0]  X_INIT   = 10'((H_ACTIVE - SQ_SIZE) / 2);
   localparam logic [9:0]  Y_INIT   = 10'((V_ACTIVE - SQ_SIZE) / 2);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

   // Saturating one-axis move; 11-bit arithmetic so neither direction wraps.
   function automatic logic [9:0] move_axis(input logic [9:0]  pos,
                                            input logic        inc,
                                            input logic        dec,
                                            input logic [10:0] lim);
      logic [10:0] p;
      logic [10:0] r;
      p = {1'b0, pos};
      r = p;
      if (inc && !dec)
         r = (p + STEP_W > lim) ? lim : p + STEP_W;
      else if (dec && !inc)
         r = (p < STEP_W) ? 11'd0 : p - STEP_W;
      return r[9:0];
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic             pix_en;
   logic [10:0]      hcount;
   logic [10:0]      vcount;
   logic             active;
   logic             in_sq;
   logic             frame_start;
   logic             hsync_p1;
   logic             vsync_p1;
   logic [11:0]      rgb_p1;
   dec_state_t       state;
   dec_state_t       state_nxt;
   logic             key_up, key_left, key_down, key_right;
   logic             up_nxt, left_nxt, down_nxt, right_nxt;
   logic [9:0]       sq_x;
   logic [9:0]       sq_y;

   assign pix_en      = (div_cnt == DIV_LAST);
   assign active      = (hcount < H_ACT_W) && (vcount < V_ACT_W);
   assign in_sq       = (hcount >= {1'b0, sq_x}) && (hcount < {1'b0, sq_x} + SQ_W) &&
                        (vcount >= {1'b0, sq_y}) && (vcount < {1'b0, sq_y} + SQ_W);
   assign frame_start = pix_en && (hcount == 11'd0) && (vcount == V_ACT_W);

   // Stage p0: pixel divider and raster counters
   // Stage p1: sync / colour registered from the current counters, so the pins
   // lag the counters by exactly one pixel slot and hold between enables.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt  <= '0;
         hcount   <= '0;
         vcount   <= '0;
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         rgb_p1   <= 12'h000;
      end else begin
         div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
         if (pix_en) begin
            hsync_p1 <= !((hcount >= HS_START) && (hcount < HS_END));
            vsync_p1 <= !((vcount >= VS_START) && (vcount < VS_END));
            rgb_p1   <= active ? (in_sq ? SQ_COLOR : BG_COLOR) : 12'h000;
            if (hcount == H_LAST) begin
               hcount <= '0;
               vcount <= (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
            end else begin
               hcount <= hcount + 11'd1;
            end
         end
      end
   end

   // Scan-code decoder: F0 prefixes a break, E0 an extended (arrow) code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         key_up    <= 1'b0;
         key_left  <= 1'b0;
         key_down  <= 1'b0;
         key_right <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_up    <= up_nxt;
         key_left  <= left_nxt;
         key_down  <= down_nxt;
         key_right <= right_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      up_nxt    = key_up;
      left_nxt  = key_left;
      down_nxt  = key_down;
      right_nxt = key_right;
      if (bus.rx_valid) begin
         case (state)
            IDLE: begin
               case (bus.rx_data)
                  8'hF0:   state_nxt = BRK;
                  8'hE0:   state_nxt = EXT;
                  8'h1D:   up_nxt    = 1'b1;
                  8'h1C:   left_nxt  = 1'b1;
                  8'h1B:   down_nxt  = 1'b1;
                  8'h23:   right_nxt = 1'b1;
                  default: ;
               endcase
            end
            BRK: begin
               state_nxt = IDLE;
               case (bus.rx_data)
                  8'h1D:   up_nxt    = 1'b0;
                  8'h1C:   left_nxt  = 1'b0;
                  8'h1B:   down_nxt  = 1'b0;
                  8'h23:   right_nxt = 1'b0;
                  default: ;
               endcase
            end
            EXT: begin
               state_nxt = IDLE;
               case (bus.rx_data)
                  8'hF0:   state_nxt = EXT_BRK;
                  8'h75:   up_nxt    = 1'b1;
                  8'h6B:   left_nxt  = 1'b1;
                  8'h72:   down_nxt  = 1'b1;
                  8'h74:   right_nxt = 1'b1;
                  default: ;
               endcase
            end
            default: begin
               state_nxt = IDLE;
               case (bus.rx_data)
                  8'h75:   up_nxt    = 1'b0;
                  8'h6B:   left_nxt  = 1'b0;
                  8'h72:   down_nxt  = 1'b0;
                  8'h74:   right_nxt = 1'b0;
                  default: ;
               endcase
            end
         endcase
      end
   end

   // Position moves only on the frame_start edge (inside vertical blank),
   // using the key flags as they stood before that edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sq_x <= X_INIT;
         sq_y <= Y_INIT;
      end else if (frame_start) begin
         sq_x <= move_axis(sq_x, key_right, key_left, X_MAX);
         sq_y <= move_axis(sq_y, key_down, key_up, Y_MAX);
      end
   end

   assign bus.hSync       = hsync_p1;
   assign bus.vSync       = vsync_p1;
   assign bus.VGA_R       = rgb_p1[11:8];
   assign bus.VGA_G       = rgb_p1[7:4];
   assign bus.VGA_B       = rgb_p1[3:0];
   assign bus.sq_x        = sq_x;
   assign bus.sq_y        = sq_y;
   assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_vga_keyboard_sprite.sv
// -----------------------------------------------------------------------------
// tb_vga_keyboard_sprite
// Bench for vga_keyboard_sprite using a shrunken raster so whole frames run
// quickly: 16/2/4/2 pixels horizontally (24 total), 12/1/2/1 lines vertically
// (16 total), 4-pixel square, step 4, background 05A so active background and
// blanking are distinguishable. Square starts at (6,4); limits are x 12, y 8.
// k counts clock edges since the last reset release; after edge k the pins
// show pixel floor(k/4)-1, and frame_start is high after edge 4*288+3.
// -----------------------------------------------------------------------------
module tb_vga_keyboard_sprite;

   localparam logic [11:0] SQ_C = 12'hF00;
   localparam logic [11:0] BG_C = 12'h05A;
   localparam int          FRAME_CLKS = 24 * 16 * 4;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   k;

   vga_keyboard_sprite_if bus ();

   vga_keyboard_sprite #(
      .CLK_DIV (4),
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SQ_SIZE (4),
      .STEP    (4),
      .SQ_COLOR(SQ_C),
      .BG_COLOR(BG_C)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          h;
      int          v;
      logic        hs;
      logic        vs;
      logic [11:0] rgb;
   } vec_t;

   vec_t vecs[18];

   function automatic logic [11:0] rgb_now();
      return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      k = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " hSync"}, 32'(bus.hSync), 32'd1);
      check({tag, " vSync"}, 32'(bus.vSync), 32'd1);
      check({tag, " rgb"}, 32'(rgb_now()), 32'h000);
      check({tag, " sq_x"}, 32'(bus.sq_x), 32'd6);
      check({tag, " sq_y"}, 32'(bus.sq_y), 32'd4);
      check({tag, " frame_start"}, 32'(bus.frame_start), 32'd0);
   endtask

   // Advance to the middle of the slot in which the pins show pixel (h,v).
   task automatic goto_pixel(input int h, input int v);
      int tgt;
      tgt = 4 * (v * 24 + h + 1) + 1;
      while (tgt <= k) tgt += FRAME_CLKS;
      while (k < tgt) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic wait_frame(input string name, input int ex, input int ey);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         tick();
         if (bus.frame_start) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: frame_start not seen within 2000 clks", name);
      end else begin
         tick();
         check({name, " sq_x"}, 32'(bus.sq_x), 32'(ex));
         check({name, " sq_y"}, 32'(bus.sq_y), 32'(ey));
      end
   endtask

   int   hs_f1, hs_r1, hs_f2, vs_f1, vs_r1, vs_f2, fs_first, fs_cnt, sq_cnt, blank_bad;
   logic hs_prev, vs_prev;

   initial begin
      checks       = 0;
      errors       = 0;
      k            = 0;
      reset        = 1'b1;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;

      vecs[0]  = '{0,  0,  1'b1, 1'b1, BG_C};
      vecs[1]  = '{5,  4,  1'b1, 1'b1, BG_C};
      vecs[2]  = '{6,  4,  1'b1, 1'b1, SQ_C};
      vecs[3]  = '{9,  7,  1'b1, 1'b1, SQ_C};
      vecs[4]  = '{10, 7,  1'b1, 1'b1, BG_C};
      vecs[5]  = '{9,  8,  1'b1, 1'b1, BG_C};
      vecs[6]  = '{6,  3,  1'b1, 1'b1, BG_C};
      vecs[7]  = '{15, 11, 1'b1, 1'b1, BG_C};
      vecs[8]  = '{16, 4,  1'b1, 1'b1, 12'h000};
      vecs[9]  = '{17, 4,  1'b1, 1'b1, 12'h000};
      vecs[10] = '{18, 4,  1'b0, 1'b1, 12'h000};
      vecs[11] = '{21, 4,  1'b0, 1'b1, 12'h000};
      vecs[12] = '{22, 4,  1'b1, 1'b1, 12'h000};
      vecs[13] = '{0,  12, 1'b1, 1'b1, 12'h000};
      vecs[14] = '{0,  13, 1'b1, 1'b0, 12'h000};
      vecs[15] = '{20, 14, 1'b0, 1'b0, 12'h000};
      vecs[16] = '{0,  15, 1'b1, 1'b1, 12'h000};
      vecs[17] = '{23, 15, 1'b1, 1'b1, 12'h000};

      #2;
      check_reset_state("reset");
      release_reset();

      // Two full frames of timing measurement straight after release.
      hs_f1 = -1; hs_r1 = -1; hs_f2 = -1;
      vs_f1 = -1; vs_r1 = -1; vs_f2 = -1;
      fs_first = -1; fs_cnt = 0; sq_cnt = 0; blank_bad = 0;
      hs_prev = 1'b1; vs_prev = 1'b1;
      for (int i = 0; i < 3200; i++) begin
         tick();
         if (k == 3) check("first slot pending rgb", 32'(rgb_now()), 32'h000);
         if (k == 4) check("first slot rgb", 32'(rgb_now()), 32'(BG_C));
         if (hs_prev && !bus.hSync) begin
            if (hs_f1 < 0) hs_f1 = k;
            else if (hs_f2 < 0) hs_f2 = k;
         end
         if (!hs_prev && bus.hSync && hs_r1 < 0) hs_r1 = k;
         if (vs_prev && !bus.vSync) begin
            if (vs_f1 < 0) vs_f1 = k;
            else if (vs_f2 < 0) vs_f2 = k;
         end
         if (!vs_prev && bus.vSync && vs_r1 < 0) vs_r1 = k;
         if (bus.frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
         end
         if ((!bus.hSync || !bus.vSync) && rgb_now() != 12'h000) blank_bad++;
         if (rgb_now() == SQ_C) sq_cnt++;
         hs_prev = bus.hSync;
         vs_prev = bus.vSync;
      end
      check("hSync first fall", 32'(hs_f1), 32'd76);
      check("hSync low width", 32'(hs_r1 - hs_f1), 32'd16);
      check("hSync period", 32'(hs_f2 - hs_f1), 32'd96);
      check("vSync first fall", 32'(vs_f1), 32'd1252);
      check("vSync low width", 32'(vs_r1 - vs_f1), 32'd192);
      check("vSync period", 32'(vs_f2 - vs_f1), 32'd1536);
      check("frame_start first", 32'(fs_first), 32'd1155);
      check("frame_start pulses", 32'(fs_cnt), 32'd2);
      check("rgb during sync", 32'(blank_bad), 32'd0);
      check("square clks", 32'(sq_cnt), 32'd128);

      // Table-driven raster vectors with the square parked at (6,4).
      for (int i = 0; i < 18; i++) begin
         goto_pixel(vecs[i].h, vecs[i].v);
         check($sformatf("vec%0d (%0d,%0d) hSync", i, vecs[i].h, vecs[i].v), 32'(bus.hSync), 32'(vecs[i].hs));
         check($sformatf("vec%0d (%0d,%0d) vSync", i, vecs[i].h, vecs[i].v), 32'(bus.vSync), 32'(vecs[i].vs));
         check($sformatf("vec%0d (%0d,%0d) rgb", i, vecs[i].h, vecs[i].v), 32'(rgb_now()), 32'(vecs[i].rgb));
      end

      // Keyboard-driven motion from a fresh reset.
      @(posedge clk);
      #1;
      reset = 1'b1;
      release_reset();

      send_byte(8'h1C);
      wait_frame("A f1", 2, 4);
      wait_frame("A f2 floor", 0, 4);
      wait_frame("A f3 floor", 0, 4);
      send_byte(8'hF0); send_byte(8'h1C);

      send_byte(8'h23);
      wait_frame("D f1", 4, 4);
      wait_frame("D f2", 8, 4);
      wait_frame("D f3", 12, 4);
      wait_frame("D f4 clamp", 12, 4);
      send_byte(8'hF0); send_byte(8'h23);
      wait_frame("D released f1", 12, 4);
      wait_frame("D released f2", 12, 4);

      send_byte(8'h1C); send_byte(8'h23);
      wait_frame("A+D held", 12, 4);
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h23);

      send_byte(8'hE0); send_byte(8'h72);
      wait_frame("down f1", 12, 8);
      wait_frame("down clamp", 12, 8);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h72);

      send_byte(8'hE0); send_byte(8'h75);
      wait_frame("up f1", 12, 4);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      wait_frame("up released", 12, 4);
      send_byte(8'hE0); send_byte(8'h75);
      wait_frame("up f2", 12, 0);
      wait_frame("up floor", 12, 0);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

      send_byte(8'h1B);
      wait_frame("S f1", 12, 4);
      send_byte(8'hF0); send_byte(8'h1B);
      wait_frame("S released", 12, 4);

      send_byte(8'hE0); send_byte(8'h1D);
      wait_frame("E0 1D no flag", 12, 4);
      send_byte(8'h1C);
      wait_frame("A after E0 1D", 8, 4);
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'h1D);
      wait_frame("W f1", 8, 0);
      send_byte(8'hF0); send_byte(8'h1D);

      // Square now at (8,0); reset asserted while it is being drawn.
      goto_pixel(9, 2);
      check("moved square pixel", 32'(rgb_now()), 32'(SQ_C));
      goto_pixel(19, 13);
      check("pre-reset hSync", 32'(bus.hSync), 32'd0);
      check("pre-reset vSync", 32'(bus.vSync), 32'd0);
      reset = 1'b1;
      #1;
      check_reset_state("mid-frame reset");
      release_reset();
      tick(); tick(); tick();
      check("resume pending rgb", 32'(rgb_now()), 32'h000);
      tick();
      check("resume pixel0 rgb", 32'(rgb_now()), 32'(BG_C));
      check("resume pixel0 hSync", 32'(bus.hSync), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
